// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-rate enable and registered outputs.
// Optional status outputs (vblank, frame_cnt) are enabled by defining VGA_TIMING_STATUS_EN.
//
// state     | meaning
// ACTIVE    | counter is inside the visible region
// FP        | counter is in the front porch
// SYNC      | counter is in the sync pulse
// BP        | counter is in the back porch
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_STATUS_EN
  ,
  output logic          vblank,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST       = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_FP_START   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SYNC_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_BP_START   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST       = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_FP_START   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SYNC_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_BP_START   = YW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phaseT;

  logic [XW-1:0] h, hNext;
  logic [YW-1:0] v, vNext;
  logic          hWrap, vWrap;
  phaseT         hState, hStateNext, vState, vStateNext;

  assign hWrap = (h == H_LAST);
  assign vWrap = (v == V_LAST);
  assign hNext = hWrap ? '0 : h + XW'(1);
  assign vNext = hWrap ? (vWrap ? '0 : v + YW'(1)) : v;

  always_ff @(posedge clk) begin
    if (rst) begin
      h      <= '0;
      v      <= '0;
      hState <= PH_ACTIVE;
      vState <= PH_ACTIVE;
    end else if (pix_en) begin
      h      <= hNext;
      v      <= vNext;
      hState <= hStateNext;
      vState <= vStateNext;
    end
  end

  // Phase changes happen on the counter value entering a region; wrap to 0 always
  // re-enters ACTIVE, which also covers a zero-length back porch.
  always_comb begin
    hStateNext = hState;
    if (hNext == '0) begin
      hStateNext = PH_ACTIVE;
    end else begin
      unique case (hState)
        PH_ACTIVE: if (hNext == H_FP_START)   hStateNext = (H_FP > 0) ? PH_FP : PH_SYNC;
        PH_FP:     if (hNext == H_SYNC_START) hStateNext = PH_SYNC;
        PH_SYNC:   if (hNext == H_BP_START)   hStateNext = PH_BP;
        PH_BP:     hStateNext = PH_BP;
        default:   hStateNext = PH_ACTIVE;
      endcase
    end
  end

  always_comb begin
    vStateNext = vState;
    if (hWrap) begin
      if (vNext == '0) begin
        vStateNext = PH_ACTIVE;
      end else begin
        unique case (vState)
          PH_ACTIVE: if (vNext == V_FP_START)   vStateNext = (V_FP > 0) ? PH_FP : PH_SYNC;
          PH_FP:     if (vNext == V_SYNC_START) vStateNext = PH_SYNC;
          PH_SYNC:   if (vNext == V_BP_START)   vStateNext = PH_BP;
          PH_BP:     vStateNext = PH_BP;
          default:   vStateNext = PH_ACTIVE;
        endcase
      end
    end
  end

  // Outputs decode the pre-increment counters, so they trail h/v by one enabled pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hsync       <= (hState == PH_SYNC) ? HS_POL : ~HS_POL;
        vsync       <= (vState == PH_SYNC) ? VS_POL : ~VS_POL;
        de          <= (hState == PH_ACTIVE) && (vState == PH_ACTIVE);
        x           <= h;
        y           <= v;
        line_start  <= (h == '0);
        frame_start <= (h == '0) && (v == '0);
      end
    end
  end

`ifdef VGA_TIMING_STATUS_EN
  logic firstFrameSeen;

  // The first frame after reset is frame 0; the count only advances on later frame starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblank         <= 1'b0;
      frame_cnt      <= '0;
      firstFrameSeen <= 1'b0;
    end else if (pix_en) begin
      vblank <= (vState != PH_ACTIVE);
      if ((h == '0) && (v == '0)) begin
        if (firstFrameSeen) frame_cnt <= frame_cnt + 16'd1;
        firstFrameSeen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small raster (H 8/2/3/3, V 4/1/2/1), both sync polarities.
// Status outputs are checked when VGA_TIMING_STATUS_EN is defined.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  logic hsync0, vsync0, de0, ls0, fs0;
  logic hsync1, vsync1, de1, ls1, fs1;
  logic [3:0] x0, x1;
  logic [2:0] y0, y1;
`ifdef VGA_TIMING_STATUS_EN
  logic vb0, vb1;
  logic [15:0] fc0, fc1;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .XW(4), .YW(3)
  ) dutLow (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hsync0), .vsync(vsync0), .de(de0), .x(x0), .y(y0),
    .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TIMING_STATUS_EN
    , .vblank(vb0), .frame_cnt(fc0)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .XW(4), .YW(3)
  ) dutHigh (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(hsync1), .vsync(vsync1), .de(de1), .x(x1), .y(y1),
    .line_start(ls1), .frame_start(fs1)
`ifdef VGA_TIMING_STATUS_EN
    , .vblank(vb1), .frame_cnt(fc1)
`endif
  );

  typedef struct {
    logic hsAct;
    logic vsAct;
    logic de;
    int   x;
    int   y;
    logic ls;
    logic fs;
    logic vb;
    int   fc;
  } expT;

  expT expQ[$];
  expT cur;
  int  mh = 0, mv = 0;
  bit  seen = 1'b0;
  int  checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts pixels and decodes the raster regions arithmetically.
  task automatic step(input logic r, input logic en);
    rst = r;
    pix_en = en;
    if (r) begin
      cur = '{hsAct: 1'b0, vsAct: 1'b0, de: 1'b0, x: 0, y: 0, ls: 1'b0, fs: 1'b0, vb: 1'b0, fc: 0};
      mh = 0;
      mv = 0;
      seen = 1'b0;
    end else if (en) begin
      cur.hsAct = (mh >= HA + HF) && (mh < HA + HF + HS);
      cur.vsAct = (mv >= VA + VF) && (mv < VA + VF + VS);
      cur.de    = (mh < HA) && (mv < VA);
      cur.x     = mh;
      cur.y     = mv;
      cur.ls    = (mh == 0);
      cur.fs    = (mh == 0) && (mv == 0);
      cur.vb    = (mv >= VA);
      if (cur.fs) begin
        if (seen) cur.fc = (cur.fc + 1) % 65536;
        seen = 1'b1;
      end
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
      end
    end else begin
      cur.ls = 1'b0;
      cur.fs = 1'b0;
    end
    expQ.push_back(cur);
    @(negedge clk);
  endtask

  initial begin : monitor
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("hsync_lowpol",  hsync0, !e.hsAct);
        check("hsync_highpol", hsync1, e.hsAct);
        check("vsync_lowpol",  vsync0, !e.vsAct);
        check("vsync_highpol", vsync1, e.vsAct);
        check("de",            de0, e.de);
        check("de_highpol",    de1, e.de);
        check("x",             x0, e.x);
        check("y",             y0, e.y);
        check("line_start",    ls0, e.ls);
        check("frame_start",   fs0, e.fs);
        check("frame_start_highpol", fs1, e.fs);
`ifdef VGA_TIMING_STATUS_EN
        check("vblank",    vb0, e.vb);
        check("frame_cnt", fc0, e.fc);
        check("frame_cnt_highpol", fc1, e.fc);
`endif
      end
    end
  end

  initial begin : driver
    bit found;
    cur = '{hsAct: 1'b0, vsAct: 1'b0, de: 1'b0, x: 0, y: 0, ls: 1'b0, fs: 1'b0, vb: 1'b0, fc: 0};
    @(negedge clk);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (3 * HT * VT + 7) step(1'b0, 1'b1);

    repeat (2 * HT * VT) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end

    found = 1'b0;
    for (int i = 0; i < 4 * HT * VT && !found; i++) begin
      step(1'b0, 1'b1);
      found = (cur.x == 5) && (cur.y == 2);
    end
    check("reach_x5_y2", found, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (HT * VT) step(1'b0, 1'b1);

    repeat (6 * HT * VT) step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0);

    repeat (3) @(negedge clk);
    check("queue_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
